// File: rtl/alu_pkg.sv
// Shared ALU definitions: add/sub operation encodings and flag bit positions.
package alu_pkg;

  localparam logic [1:0] ADDSUB_ADD = 2'b00;
  localparam logic [1:0] ADDSUB_SUB = 2'b01;
  localparam logic [1:0] ADDSUB_ADC = 2'b10;
  localparam logic [1:0] ADDSUB_SBC = 2'b11;

  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;
  localparam int NFLAGS = 4;

endpackage

// File: rtl/pipelined_cla_addsub_cla_slice.sv
// Combinational BLOCK-bit carry-lookahead slice: group generate/propagate prefixes give every
// internal carry directly from the slice carry-in.
module cla_slice
  import alu_pkg::*;
#(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] gg;
  logic [BLOCK-1:0] pp;
  logic [BLOCK:0]   c;

  always_comb begin
    g     = a & b;
    p     = a | b;
    gg    = '0;
    pp    = '0;
    c     = '0;
    gg[0] = g[0];
    pp[0] = p[0];
    for (int i = 1; i < BLOCK; i++) begin
      gg[i] = g[i] | (p[i] & gg[i-1]);
      pp[i] = p[i] & pp[i-1];
    end
    // gg/pp[i] span bits i..0, so each carry is one AND-OR away from cin
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      c[i+1] = gg[i] | (pp[i] & cin);
    end
    s = a ^ b ^ c[BLOCK-1:0];
  end

  assign cout     = c[BLOCK];
  assign c_msb_in = c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined add/sub: one lookahead slice per stage, carry registered between stages,
// valid/ready handshake with a per-stage advance chain and NZCV-style flags.
module pipelined_cla_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NSTAGES = WIDTH / BLOCK;

  if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_param_check
    $error("pipelined_cla_addsub: WIDTH must be a positive multiple of BLOCK");
  end

  logic [NSTAGES-1:0] v;
  logic [NSTAGES-1:0] adv;
  logic [NSTAGES-1:0] ld;
  logic [NSTAGES-1:0] vin;

  // w carries finished sum bits below the current slice and raw a bits from it upward
  logic [WIDTH-1:0] w_in [NSTAGES];
  logic [WIDTH-1:0] b_in [NSTAGES];
  logic [WIDTH-1:0] w_q  [NSTAGES];
  logic [WIDTH-1:0] b_q  [NSTAGES];
  logic             c_in [NSTAGES];
  logic             z_in [NSTAGES];
  logic             c_q  [NSTAGES];
  logic             z_q  [NSTAGES];
  logic             cmsb [NSTAGES];

  logic [WIDTH-1:0]  sum_q;
  logic [NFLAGS-1:0] flags_q;
  logic [WIDTH-1:0]  b_eff;
  logic              c0;

  assign b_eff = (op == ADDSUB_SUB || op == ADDSUB_SBC) ? ~b : b;
  assign c0    = (op == ADDSUB_ADC || op == ADDSUB_SBC) ? cin : (op == ADDSUB_SUB);

  always_comb begin
    adv            = '0;
    adv[NSTAGES-1] = out_ready | ~v[NSTAGES-1];
    for (int k = NSTAGES - 2; k >= 0; k--) begin
      adv[k] = adv[k+1] | ~v[k+1];
    end
  end

  assign ld       = adv | ~v;
  assign in_ready = rst_n & ld[0];

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    logic [BLOCK-1:0] s;
    logic             s_cout;
    logic [WIDTH-1:0] w_nxt;
    logic             z_nxt;
    logic             v_r;

    if (k == 0) begin : g_first
      assign w_in[k] = a;
      assign b_in[k] = b_eff;
      assign c_in[k] = c0;
      assign z_in[k] = 1'b1;
      assign vin[k]  = in_valid & in_ready;
    end else begin : g_next
      assign w_in[k] = w_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign z_in[k] = z_q[k-1];
      assign vin[k]  = v[k-1];
    end

    cla_slice #(.BLOCK(BLOCK)) u_slice (
      .a        (w_in[k][k*BLOCK +: BLOCK]),
      .b        (b_in[k][k*BLOCK +: BLOCK]),
      .cin      (c_in[k]),
      .s        (s),
      .cout     (s_cout),
      .c_msb_in (cmsb[k])
    );

    always_comb begin
      w_nxt                      = w_in[k];
      w_nxt[k*BLOCK +: BLOCK]    = s;
    end

    assign z_nxt = z_in[k] & (s == '0);

    // ---- stage k register boundary ----
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_r <= 1'b0;
      end else if (ld[k]) begin
        v_r <= vin[k];
      end
    end

    assign v[k] = v_r;

    if (k < NSTAGES - 1) begin : g_mid
      logic [WIDTH-1:0] w_r;
      logic [WIDTH-1:0] b_r;
      logic             c_r;
      logic             z_r;

      always_ff @(posedge clk) begin
        if (ld[k] && vin[k]) begin
          w_r <= w_nxt;
          b_r <= b_in[k];
          c_r <= s_cout;
          z_r <= z_nxt;
        end
      end

      assign w_q[k] = w_r;
      assign b_q[k] = b_r;
      assign c_q[k] = c_r;
      assign z_q[k] = z_r;
    end else begin : g_last
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sum_q   <= '0;
          flags_q <= '0;
        end else if (ld[k] && vin[k]) begin
          sum_q           <= w_nxt;
          flags_q[FLAG_C] <= s_cout;
          flags_q[FLAG_V] <= s_cout ^ cmsb[k];
          flags_q[FLAG_Z] <= z_nxt;
          flags_q[FLAG_N] <= w_nxt[WIDTH-1];
        end
      end
    end
  end

  assign out_valid = v[NSTAGES-1];
  assign sum       = sum_q;
  assign cout      = flags_q[FLAG_C];
  assign ovf       = flags_q[FLAG_V];
  assign zero      = flags_q[FLAG_Z];
  assign neg       = flags_q[FLAG_N];

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: directed vectors on three slice configurations,
// randomized back-pressure traffic against an arithmetic model, and mid-flight reset.
module tb_pipelined_cla_addsub;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } res_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    res_t        exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        cin;

  logic        iv0, ir0, ov0, or0, co0, ovf0, z0, n0;
  logic [31:0] sum0;
  logic        iv1, ir1, ov1, co1, ovf1, z1, n1;
  logic [31:0] sum1;
  logic        iv2, ir2, ov2, co2, ovf2, z2, n2;
  logic [31:0] sum2;

  int tests = 0;
  int fails = 0;

  pipelined_cla_addsub #(.WIDTH(32), .BLOCK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .op(op), .a(a), .b(b), .cin(cin),
    .out_valid(ov0), .out_ready(or0), .sum(sum0), .cout(co0), .ovf(ovf0), .zero(z0), .neg(n0));

  pipelined_cla_addsub #(.WIDTH(32), .BLOCK(32)) dut_b32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .op(op), .a(a), .b(b), .cin(cin),
    .out_valid(ov1), .out_ready(1'b1), .sum(sum1), .cout(co1), .ovf(ovf1), .zero(z1), .neg(n1));

  pipelined_cla_addsub #(.WIDTH(32), .BLOCK(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .op(op), .a(a), .b(b), .cin(cin),
    .out_valid(ov2), .out_ready(1'b1), .sum(sum2), .cout(co2), .ovf(ovf2), .zero(z2), .neg(n2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic ci);
    logic [32:0] full;
    logic [31:0] yy;
    res_t        r;
    case (o)
      2'b00:   begin yy = y;  full = {1'b0, x} + {1'b0, yy};                  end
      2'b01:   begin yy = ~y; full = {1'b0, x} + {1'b0, yy} + 33'd1;          end
      2'b10:   begin yy = y;  full = {1'b0, x} + {1'b0, yy} + {32'd0, ci};    end
      default: begin yy = ~y; full = {1'b0, x} + {1'b0, yy} + {32'd0, ci};    end
    endcase
    r.sum  = full[31:0];
    r.cout = full[32];
    r.ovf  = (x[31] == yy[31]) && (r.sum[31] != x[31]);
    r.zero = (r.sum == 32'd0);
    r.neg  = r.sum[31];
    return r;
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  vec_t vecs [8];

  task automatic run_vec(input int i);
    res_t r   [3];
    int   lat [3];
    bit   seen[3];
    for (int d = 0; d < 3; d++) begin
      lat[d]  = 0;
      seen[d] = 1'b0;
      r[d]    = '0;
    end
    op  = vecs[i].op;
    a   = vecs[i].a;
    b   = vecs[i].b;
    cin = vecs[i].cin;
    iv0 = 1'b1; iv1 = 1'b1; iv2 = 1'b1;
    chk($sformatf("v%0d_in_ready_b8", i), {63'd0, ir0}, 64'd1);
    chk($sformatf("v%0d_in_ready_b1", i), {63'd0, ir2}, 64'd1);
    @(posedge clk); #1;
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (!seen[0] && ov0) begin seen[0] = 1'b1; lat[0] = c; r[0] = {sum0, co0, ovf0, z0, n0}; end
      if (!seen[1] && ov1) begin seen[1] = 1'b1; lat[1] = c; r[1] = {sum1, co1, ovf1, z1, n1}; end
      if (!seen[2] && ov2) begin seen[2] = 1'b1; lat[2] = c; r[2] = {sum2, co2, ovf2, z2, n2}; end
      if (seen[0] && seen[1] && seen[2]) break;
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d_latency_b8", i),  64'(lat[0]), 64'd4);
    chk($sformatf("v%0d_latency_b32", i), 64'(lat[1]), 64'd1);
    chk($sformatf("v%0d_latency_b1", i),  64'(lat[2]), 64'd32);
    chk($sformatf("v%0d_result_b8", i),   64'(r[0]), 64'(vecs[i].exp));
    chk($sformatf("v%0d_result_b32", i),  64'(r[1]), 64'(vecs[i].exp));
    chk($sformatf("v%0d_result_b1", i),   64'(r[2]), 64'(vecs[i].exp));
    @(posedge clk); #1;
  endtask

  initial begin
    res_t q[$];
    res_t exp_r, held;
    bit   hold;
    bit   acc, pop;
    int   sent, recv, cyc, seen_ov;

    // {op, a, b, cin, {sum, cout, ovf, zero, neg}}
    vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[1] = '{2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[2] = '{2'b01, 32'h0000_0000, 32'h0000_0001, 1'b0, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[3] = '{2'b10, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, '{32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1}};
    vecs[4] = '{2'b00, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, '{32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[5] = '{2'b11, 32'h0000_0005, 32'h0000_0003, 1'b0, '{32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[6] = '{2'b11, 32'h0000_0005, 32'h0000_0003, 1'b1, '{32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[7] = '{2'b01, 32'h0000_0005, 32'h0000_0005, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0}};

    rst_n = 1'b0; iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0; or0 = 1'b1;
    op = 2'b00; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'd0, ov0}, 64'd0);
    chk("reset_in_ready",  {63'd0, ir0}, 64'd0);
    chk("reset_outputs",   64'({sum0, co0, ovf0, z0, n0}), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", {63'd0, ir0}, 64'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Random back-to-back traffic with random back-pressure
    sent = 0; recv = 0; cyc = 0; hold = 1'b0; held = '0;
    op = 2'($urandom); a = rnd_word(); b = rnd_word(); cin = 1'($urandom);
    iv0 = 1'b1; or0 = 1'($urandom);
    while (recv < 1000 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        chk("stall_valid", {63'd0, ov0}, 64'd1);
        chk("stall_data",  64'({sum0, co0, ovf0, z0, n0}), 64'(held));
      end
      acc = iv0 & ir0;
      pop = ov0 & or0;
      if (acc) begin
        q.push_back(model(op, a, b, cin));
        sent++;
      end
      if (pop) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          exp_r = q.pop_front();
          chk($sformatf("rand_result_%0d", recv), 64'({sum0, co0, ovf0, z0, n0}), 64'(exp_r));
        end
        recv++;
      end
      hold = ov0 & ~or0;
      held = {sum0, co0, ovf0, z0, n0};
      @(posedge clk); #1;
      if (acc) begin
        if (sent < 1000) begin
          op = 2'($urandom); a = rnd_word(); b = rnd_word(); cin = 1'($urandom);
        end else begin
          iv0 = 1'b0;
        end
      end
      or0 = 1'($urandom);
    end
    chk("rand_all_received", 64'(recv), 64'd1000);
    chk("rand_none_left",    64'(q.size()), 64'd0);
    iv0 = 1'b0; or0 = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Reset with three requests in flight, oldest stalled at the output
    or0 = 1'b0;
    op = 2'b00; a = 32'h0000_0011; b = 32'h0000_0022; cin = 1'b0;
    iv0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    iv0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("inflight_out_valid", {63'd0, ov0}, 64'd1);
    chk("inflight_sum", 64'(sum0), 64'h33);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset_out_valid", {63'd0, ov0}, 64'd0);
    chk("midreset_outputs",   64'({sum0, co0, ovf0, z0, n0}), 64'd0);
    rst_n = 1'b1;
    or0 = 1'b1;
    seen_ov = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (ov0) seen_ov++;
    end
    chk("no_stale_after_reset", 64'(seen_ov), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
